y86_regfile_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined Y86-64 core; replaces the single-cycle decode-stage register array.
- Two combinational read ports (srcA, srcB) with write-through bypass.
- Two synchronous write ports: E from execute, M from memory.
- Per-register pending-write scoreboard so decode can detect load/use hazards; full register dump bus for the testbench.

---
 rtl/y86_pkg.sv | 45 ++++
 rtl/y86_sb_scoreboard.sv | 50 +++++
 rtl/y86_regfile_mp.sv | 93 +++++++++
 tb/tb_y86_regfile_mp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register ids, instruction codes and the
// register-file reset pattern.
package y86_pkg;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RCX = 4'd1;
    localparam logic [3:0] RDX = 4'd2;
    localparam logic [3:0] RBX = 4'd3;
    localparam logic [3:0] RSP = 4'd4;
    localparam logic [3:0] RBP = 4'd5;
    localparam logic [3:0] RSI = 4'd6;
    localparam logic [3:0] RDI = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    // Low registers count by two; from reg5 upward each value doubles (16 .. 8192).
    function automatic logic [63:0] regfile_init(input int unsigned i);
        if (i < 32'd5) begin
            return 64'(2 * i);
        end
        return 64'd1 << (i - 32'd1);
    endfunction

endpackage

// File: rtl/y86_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by
// either write port, with busy reads masked by writes completing this cycle.
module y86_sb_scoreboard
    import y86_pkg::*;
#(
    parameter int unsigned NREGS = 15,
    parameter int unsigned IDW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] issue_id,
    input  logic [IDW-1:0] dstE,
    input  logic [IDW-1:0] dstM,
    input  logic [IDW-1:0] srcA,
    input  logic [IDW-1:0] srcB,
    output logic           busyA,
    output logic           busyB
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;
    logic [NREGS-1:0] wr;

    always_comb begin
        wr    = '0;
        sb_d  = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            wr[i] = (dstE == IDW'(i)) || (dstM == IDW'(i));
            // A new issue outranks a retiring write: it is the younger producer.
            sb_d[i] = (issue_id == IDW'(i)) || (sb_q[i] && !wr[i]);
            if (srcA == IDW'(i)) begin
                busyA = sb_q[i] && !wr[i];
            end
            if (srcB == IDW'(i)) begin
                busyB = sb_q[i] && !wr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/y86_regfile_mp.sv
// Two-read, two-write Y86-64 register file with write-through bypass,
// pending-write scoreboard and a committed-state dump bus.
module y86_regfile_mp
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned NREGS  = 15,
    parameter int unsigned IDW    = 4,
    parameter int unsigned RSP_ID = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDW-1:0]         srcA,
    input  logic [IDW-1:0]         srcB,
    output logic [WIDTH-1:0]       valA,
    output logic [WIDTH-1:0]       valB,
    output logic                   busyA,
    output logic                   busyB,
    input  logic [IDW-1:0]         dstE,
    input  logic [WIDTH-1:0]       valE,
    input  logic [IDW-1:0]         dstM,
    input  logic [WIDTH-1:0]       valM,
    input  logic [IDW-1:0]         issue_id,
    output logic [WIDTH-1:0]       rsp_o,
    output logic [NREGS*WIDTH-1:0] dump
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // M is applied after E so it wins on a shared destination; ids that
    // match no register (F or >= NREGS) fall through untouched.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (dstE == IDW'(i)) begin
                regs_d[i] = valE;
            end
            if (dstM == IDW'(i)) begin
                regs_d[i] = valM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= WIDTH'(regfile_init(i));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading the next-state array gives the bypass with the same M-over-E priority.
    always_comb begin
        valA = '0;
        valB = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (srcA == IDW'(i)) begin
                valA = regs_d[i];
            end
            if (srcB == IDW'(i)) begin
                valB = regs_d[i];
            end
        end
    end

    always_comb begin
        dump = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            dump[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    assign rsp_o = regs_q[RSP_ID];

    y86_sb_scoreboard #(
        .NREGS(NREGS),
        .IDW  (IDW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .issue_id(issue_id),
        .dstE    (dstE),
        .dstM    (dstM),
        .srcA    (srcA),
        .srcB    (srcB),
        .busyA   (busyA),
        .busyB   (busyB)
    );

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Bench for y86_regfile_mp: directed stimulus pushes expectations into a
// queue that a negedge monitor pops and compares.
module tb_y86_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]      srcA, srcB, dstE, dstM, issue_id;
    logic [63:0]     valE, valM, valA, valB, rsp_o;
    logic            busyA, busyB;
    logic [15*64-1:0] dump;

    logic [3:0]      s_srcA, s_srcB, s_dstE, s_dstM, s_issue;
    logic [63:0]     s_valE, s_valM, s_valA, s_valB, s_rsp;
    logic            s_busyA, s_busyB;
    logic [8*64-1:0] s_dump;

    always #5 clk = ~clk;

    y86_regfile_mp dut (
        .clk(clk), .rst(rst),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .busyA(busyA), .busyB(busyB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .issue_id(issue_id), .rsp_o(rsp_o), .dump(dump)
    );

    y86_regfile_mp #(.NREGS(8)) dut_s (
        .clk(clk), .rst(rst),
        .srcA(s_srcA), .srcB(s_srcB), .valA(s_valA), .valB(s_valB),
        .busyA(s_busyA), .busyB(s_busyB),
        .dstE(s_dstE), .valE(s_valE), .dstM(s_dstM), .valM(s_valM),
        .issue_id(s_issue), .rsp_o(s_rsp), .dump(s_dump)
    );

    typedef enum int {K_VALA, K_VALB, K_BUSYA, K_BUSYB, K_RSP, K_DUMP,
                      K_SVALA, K_SVALB, K_SBUSYA, K_SDUMP} kind_t;
    typedef struct {
        kind_t       kind;
        int          idx;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [63:0] model [15];

    function automatic logic [63:0] init_val(input int i);
        if (i < 5) return 64'(2 * i);
        return 64'd1 << (i - 1);
    endfunction

    function automatic logic [63:0] actual(input kind_t k, input int idx);
        case (k)
            K_VALA:   return valA;
            K_VALB:   return valB;
            K_BUSYA:  return {63'd0, busyA};
            K_BUSYB:  return {63'd0, busyB};
            K_RSP:    return rsp_o;
            K_DUMP:   return dump[idx*64 +: 64];
            K_SVALA:  return s_valA;
            K_SVALB:  return s_valB;
            K_SBUSYA: return {63'd0, s_busyA};
            default:  return s_dump[idx*64 +: 64];
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.kind, e.idx);
            n_vec++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h, expected %h", e.name, e.idx, a, e.exp);
            end
        end
    end

    task automatic push_exp(input kind_t k, input int idx, input logic [63:0] v, input string nm);
        q.push_back('{k, idx, v, nm});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF; issue_id = 4'hF;
        valE = '0; valM = '0;
        s_srcA = 4'hF; s_srcB = 4'hF; s_dstE = 4'hF; s_dstM = 4'hF; s_issue = 4'hF;
        s_valE = '0; s_valM = '0;
    endtask

    task automatic check_dump(input string nm);
        for (int i = 0; i < 15; i++) push_exp(K_DUMP, i, model[i], nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 15; i++) model[i] = init_val(i);
        repeat (2) tick();
        rst = 1'b0;
        check_dump("reset_dump");
        push_exp(K_RSP, 0, 64'd8, "reset_rsp");
        push_exp(K_BUSYA, 0, 64'd0, "reset_busyA");
        push_exp(K_BUSYB, 0, 64'd0, "reset_busyB");
        push_exp(K_DUMP, 14, 64'd8192, "reset_r14");
        for (int i = 0; i < 8; i++) push_exp(K_SDUMP, i, init_val(i), "reset_sdump");

        // dual write
        tick(); idle();
        dstE = 4'd1; valE = 64'h11; dstM = 4'd2; valM = 64'h22; srcA = 4'd1; srcB = 4'd2;
        push_exp(K_VALA, 0, 64'h11, "dual_bypassA");
        push_exp(K_VALB, 0, 64'h22, "dual_bypassB");
        push_exp(K_DUMP, 1, 64'd2, "dual_precommit");
        tick(); idle();
        srcA = 4'd1; srcB = 4'd2;
        model[1] = 64'h11; model[2] = 64'h22;
        push_exp(K_VALA, 0, 64'h11, "dual_readA");
        push_exp(K_VALB, 0, 64'h22, "dual_readB");
        check_dump("dual_dump");

        // same destination on both ports
        tick(); idle();
        dstE = 4'd4; valE = 64'h100; dstM = 4'd4; valM = 64'h200; srcA = 4'd4; srcB = 4'd4;
        push_exp(K_VALA, 0, 64'h200, "conflict_valA");
        push_exp(K_VALB, 0, 64'h200, "conflict_valB");
        push_exp(K_RSP, 0, 64'd8, "conflict_rsp_pre");
        tick(); idle();
        model[4] = 64'h200;
        push_exp(K_RSP, 0, 64'h200, "conflict_rsp_post");

        // bypass and no-register reads
        tick(); idle();
        srcA = 4'd3; dstE = 4'd3; valE = 64'hABC;
        push_exp(K_VALA, 0, 64'hABC, "bypass_valA");
        push_exp(K_VALB, 0, 64'd0, "none_valB");
        push_exp(K_DUMP, 3, 64'd6, "bypass_precommit");
        tick(); idle();
        model[3] = 64'hABC;
        srcA = 4'd3; valE = 64'hDEAD; valM = 64'hBEEF;
        push_exp(K_VALA, 0, 64'hABC, "bypass_committed");
        tick(); idle();
        check_dump("nowrite_dump");

        // rsp_o shows committed state only
        tick(); idle();
        dstM = 4'd4; valM = 64'h999; srcB = 4'd4;
        push_exp(K_VALB, 0, 64'h999, "rsp_bypassB");
        push_exp(K_RSP, 0, 64'h200, "rsp_nobypass");
        tick(); idle();
        model[4] = 64'h999;
        push_exp(K_RSP, 0, 64'h999, "rsp_commit");

        // scoreboard
        tick(); idle();
        issue_id = 4'd5; srcA = 4'd5;
        push_exp(K_BUSYA, 0, 64'd0, "sb_before_set");
        tick(); idle();
        srcA = 4'd5; srcB = 4'd5;
        push_exp(K_BUSYA, 0, 64'd1, "sb_setA");
        push_exp(K_BUSYB, 0, 64'd1, "sb_setB");
        tick(); idle();
        srcA = 4'd5; dstM = 4'd5; valM = 64'h55;
        push_exp(K_BUSYA, 0, 64'd0, "sb_masked");
        push_exp(K_VALA, 0, 64'h55, "sb_bypass");
        tick(); idle();
        model[5] = 64'h55;
        srcA = 4'd5;
        push_exp(K_BUSYA, 0, 64'd0, "sb_cleared");
        tick(); idle();
        srcA = 4'd5; issue_id = 4'd5; dstE = 4'd5; valE = 64'h66;
        push_exp(K_BUSYA, 0, 64'd0, "sb_setclr_same");
        push_exp(K_VALA, 0, 64'h66, "sb_setclr_val");
        tick(); idle();
        model[5] = 64'h66;
        srcA = 4'd5;
        push_exp(K_BUSYA, 0, 64'd1, "sb_set_wins");
        tick(); idle();
        issue_id = 4'd7;
        tick(); idle();
        srcA = 4'd7; srcB = 4'd5;
        push_exp(K_BUSYA, 0, 64'd1, "sb_r7");
        push_exp(K_BUSYB, 0, 64'd1, "sb_r5_still");

        // out of range on the 15-register instance
        tick(); idle();
        dstE = 4'hF; valE = '1; srcA = 4'hF; issue_id = 4'hF;
        push_exp(K_VALA, 0, 64'd0, "oor_valA");
        push_exp(K_BUSYA, 0, 64'd0, "oor_busyA");
        tick(); idle();
        check_dump("oor_dump");

        // 8-register instance: id 10 is ignored
        tick(); idle();
        s_dstE = 4'd10; s_valE = 64'h1234; s_srcA = 4'd10; s_issue = 4'd10;
        s_dstM = 4'd7; s_valM = 64'h77; s_srcB = 4'd7;
        push_exp(K_SVALA, 0, 64'd0, "small_oor_read");
        push_exp(K_SVALB, 0, 64'h77, "small_bypass");
        tick(); idle();
        s_srcA = 4'd10;
        push_exp(K_SVALA, 0, 64'd0, "small_oor_read2");
        push_exp(K_SBUSYA, 0, 64'd0, "small_oor_busy");
        for (int i = 0; i < 7; i++) push_exp(K_SDUMP, i, init_val(i), "small_dump");
        push_exp(K_SDUMP, 7, 64'h77, "small_dump");

        // mid-run asynchronous reset cancelling a pending write
        tick(); idle();
        dstE = 4'd1; valE = 64'hAAAA; srcA = 4'd7; srcB = 4'd5;
        #1 rst = 1'b1;
        for (int i = 0; i < 15; i++) model[i] = init_val(i);
        check_dump("arst_dump");
        push_exp(K_BUSYA, 0, 64'd0, "arst_busyA");
        push_exp(K_BUSYB, 0, 64'd0, "arst_busyB");
        push_exp(K_RSP, 0, 64'd8, "arst_rsp");
        push_exp(K_VALA, 0, 64'd64, "arst_valA");
        push_exp(K_SDUMP, 7, 64'd64, "arst_sdump7");
        tick();
        push_exp(K_DUMP, 1, 64'd2, "arst_write_cancel");
        tick();
        rst = 1'b0;
        idle();
        srcA = 4'd7;
        push_exp(K_DUMP, 1, 64'd2, "arst_after");
        push_exp(K_BUSYA, 0, 64'd0, "arst_after_busy");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
